booth_mult_r4: RTL and testbench
================================

# booth_mult_r4

Parametrised radix-4 (modified) Booth multiplier: the iterative successor to the 16-bit radix-2 Booth multiplier. It adds configurable operand width, a signed/unsigned mode and a start/busy/done handshake that replaces the external `ld`/`ld_PP` sequencing. Each step retires two multiplier bits. It sits between operand registers and the datapath result bus. The product is held stable until the next completion.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be even and ≥ 4.
- `clk`, input, 1: the only clock. Everything is sampled on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE.
- `in_A`, input, WIDTH: multiplicand. Captured on the accepting edge.
- `in_B`, input, WIDTH: multiplier. Captured on the accepting edge.
- `signed_mode`, input, 1: 1 means two's-complement operands, 0 means unsigned. Captured with the operands.
- `acc_en`, input, 1: accumulate request. This port exists only with `BOOTH_ACCUM_EN` defined.
- `busy`, output, 1: high in CALC and DONE.
- `done`, output, 1: one-cycle pulse when `product` is updated.
- `product`, output, 2*WIDTH: result register.

## Operation
- **Operand extension:**
  - Both operands are extended to WIDTH+2 bits: sign-extended when `signed_mode`=1, zero-extended when 0.
  - The multiplier gets an implicit bit 0 appended below its LSB, giving N = WIDTH/2+1 Booth digits.
- **Digit recoding:** each step takes the triplet {b[2i+1], b[2i], b[2i−1]} and maps it to a digit in {−2, −1, 0, +1, +2}.
- **Partial product:** the digit times the extended multiplicand, held in a 2*WIDTH+4-bit accumulator.
- **Per-step update:** add the partial product to the upper part of the accumulator, then arithmetic-shift the accumulator right by 2.
- **Result:** `product` takes the low 2*WIDTH bits of the final accumulator, which is exact for both modes. `product` is modulo 2^(2*WIDTH) only when accumulating.
- **FSM:**
  - IDLE: with `start`=1, capture the operands, clear the accumulator, load the step counter with N, go to CALC. With `start`=0, stay in IDLE.
  - CALC: perform one step per cycle and decrement the counter. After the step with counter = 1, write `product` and go to DONE.
  - DONE: `done`=1. Go to IDLE unconditionally.
- **`start` outside IDLE:** ignored, no queuing.
- **Operand inputs:** changes to `in_A`, `in_B` or `signed_mode` after the accepting edge have no effect.
- **Async `reset` (any state, including mid-CALC):**
  - State goes to IDLE and the accumulator and counter clear.
  - `product`=0, `busy`=0, `done`=0.
  - The in-flight operation is discarded, and no `done` is produced for it.

## Timing
- **Reset values:** `product`=0, `busy`=0, `done`=0, state IDLE.
- **Accept:** `start` is accepted at edge E. `busy` rises after E.
- **Completion:**
  - `product` updates and `done` pulses high in the cycle following edge E+N. For WIDTH=16 that is E+9.
  - `busy` falls after edge E+N+1.
- **Throughput:** the earliest next accept is edge E+N+2, so one result every N+2 cycles.
- **Output timing:** `product` and `done` are registered outputs. There is no combinational path from any input to any output.

## Configuration
- **`BOOTH_ACCUM_EN` defined:**
  - The `acc_en` port exists and is captured with `start`.
  - When `acc_en`=1, completion writes the old `product` plus the new product, wrapping modulo 2^(2*WIDTH).
  - When `acc_en`=0, completion writes the product only.
  - Latency is unchanged.
- **`BOOTH_ACCUM_EN` undefined:** there is no `acc_en` port, and completion always overwrites `product`.

## Structure
- **Package `booth_pkg`:**
  - State enum `booth_state_e` {IDLE, CALC, DONE}.
  - Digit typedef `booth_digit_t`, holding the neg/one/two select fields.
  - The function computing N from WIDTH.
- **Sub-module `booth_r4_encoder`:** combinational. Maps the 3-bit triplet to `booth_digit_t`.
- **Top module `booth_mult_r4`:** contains the FSM, step counter, operand registers, accumulator and adder.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → `product`=0, `busy`=0, `done`=0 immediately.
- **Signed:** WIDTH=16, signed_mode=1, in_A=16'hFFFD (−3), in_B=16'h0007 → `product`=32'hFFFFFFEB, with `done` in the cycle after edge E+9.
- **Unsigned:** signed_mode=0, in_A=16'hFFFF, in_B=16'hFFFF → 32'hFFFE0001. The same operands with signed_mode=1 → 32'h00000001.
- **Signed extremes:** in_A=in_B=16'h8000 with signed_mode=1 → 32'h40000000. in_A=16'h7FFF, in_B=16'h8000 → 32'hC0008000.
- **Ignored start and mid-operation reset:**
  - Pulse `start` at E+3 with other operands → ignored, and the result is still the first operation's.
  - Assert `reset` at E+4 of another operation → no `done`, `product`=0.
  - The next operation, 5×6, gives 30.
- **Accumulate (with `BOOTH_ACCUM_EN`):** 3×4 with acc_en=0 → 12. Then 5×6 with acc_en=1 → 42. Then 16'hFFFF×16'hFFFF unsigned with acc_en=1 → 32'hFFFE002B.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded digit, digit count.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // One radix-4 digit in sign/magnitude select form: value = (neg ? -1 : 1) * (one ? 1 : two ? 2 : 0).
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Operands are extended by two bits, so the extended multiplier yields width/2+1 digits.
  function automatic int booth_num_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth recoder: triplet {b[2i+1], b[2i], b[2i-1]} to a select digit.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   i_triplet,
  output booth_digit_t o_digit
);

  always_comb begin
    // NOTE: default every field first so no path through the case leaves a latch behind.
    o_digit = '0;
    case (i_triplet)
      3'b001, 3'b010: o_digit.one = 1'b1;
      3'b011:         o_digit.two = 1'b1;
      3'b100:         begin o_digit.neg = 1'b1; o_digit.two = 1'b1; end
      3'b101, 3'b110: begin o_digit.neg = 1'b1; o_digit.one = 1'b1; end
      default:        o_digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle, start/busy/done handshake.
// Define BOOTH_ACCUM_EN to add the acc_en port and accumulate-into-product completion.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_A,
  input  logic [WIDTH-1:0]     in_B,
  input  logic                 signed_mode,
`ifdef BOOTH_ACCUM_EN
  input  logic                 acc_en,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N     = booth_num_digits(WIDTH);
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * EXT_W;
  localparam int CNT_W = $clog2(N + 1);

  booth_state_e r_state, w_state_next;

  logic [EXT_W-1:0]        r_a;
  logic [EXT_W:0]          r_b;      // extended multiplier with the implicit 0 below its LSB
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;

  booth_digit_t            w_digit;
  logic signed [EXT_W:0]   w_mag;
  logic signed [EXT_W:0]   w_pp;
  logic signed [EXT_W:0]   w_sum;
  logic [ACC_W:0]          w_wide;
  logic [ACC_W-1:0]        w_acc_next;
  logic [EXT_W-1:0]        w_a_ext;
  logic [EXT_W-1:0]        w_b_ext;
  logic [2*WIDTH-1:0]      w_base;
  logic                    w_accept;
  logic                    w_last;

  booth_r4_encoder u_enc (
    .i_triplet (r_b[2:0]),
    .o_digit   (w_digit)
  );

  assign w_a_ext = signed_mode ? {{2{in_A[WIDTH-1]}}, in_A} : {2'b00, in_A};
  assign w_b_ext = signed_mode ? {{2{in_B[WIDTH-1]}}, in_B} : {2'b00, in_B};

  assign w_mag  = w_digit.one ? $signed({r_a[EXT_W-1], r_a}) :
                  w_digit.two ? $signed({r_a, 1'b0}) : '0;
  assign w_pp   = w_digit.neg ? -w_mag : w_mag;

  // One guard bit on the upper-half sum keeps the pre-shift value from overflowing.
  assign w_sum      = $signed({r_acc[ACC_W-1], r_acc[ACC_W-1:EXT_W]}) + w_pp;
  assign w_wide     = {w_sum, r_acc[EXT_W-1:0]};
  assign w_acc_next = {w_wide[ACC_W], w_wide[ACC_W:2]};

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(1));

`ifdef BOOTH_ACCUM_EN
  logic r_acc_en;
  assign w_base = r_acc_en ? product : '0;
`else
  assign w_base = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      CALC:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // NOTE: the operand registers are reset along with the control state; they are few bits and it keeps the datapath deterministic after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      product <= '0;
`ifdef BOOTH_ACCUM_EN
      r_acc_en <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= w_a_ext;
      r_b   <= {w_b_ext, 1'b0};
      r_acc <= '0;
      r_cnt <= CNT_W'(N);
`ifdef BOOTH_ACCUM_EN
      r_acc_en <= acc_en;
`endif
    end else if (r_state == CALC) begin
      r_acc <= w_acc_next;
      r_b   <= {2'b00, r_b[EXT_W:2]};
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) product <= w_base + w_acc_next[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 (WIDTH=16): directed cases plus random operands vs. an arithmetic model.
module tb_booth_mult_r4;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2 + 1;
`ifdef BOOTH_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  in_A;
  logic [WIDTH-1:0]  in_B;
  logic              signed_mode;
`ifdef BOOTH_ACCUM_EN
  logic              acc_en;
`endif
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] product;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*WIDTH-1:0] exp_prod = '0;

  always #5 clk = ~clk;

  booth_mult_r4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_A        (in_A),
    .in_B        (in_B),
    .signed_mode (signed_mode),
`ifdef BOOTH_ACCUM_EN
    .acc_en      (acc_en),
`endif
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic sm);
    longint x, y;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    return (2*WIDTH)'(x * y);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives an accepted request; returns at the falling edge right after accepting edge E.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                        input logic acc, input string tag);
    @(negedge clk);
    in_A = a; in_B = b; signed_mode = sm; start = 1'b1;
`ifdef BOOTH_ACCUM_EN
    acc_en = acc;
`endif
    exp_prod = ((acc && ACCUM) ? exp_prod : '0) + ref_mul(a, b, sm);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_A = WIDTH'($urandom); in_B = WIDTH'($urandom); signed_mode = 1'($urandom);
    check({tag, "_busy_rise"}, busy, 1);
  endtask

  task automatic wait_done(input string tag, input int start_cyc);
    int cyc = start_cyc;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, N);
    check({tag, "_product"}, product, exp_prod);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    logic seen_done;
    reset = 1'b1; start = 1'b0; in_A = '0; in_B = '0; signed_mode = 1'b0;
`ifdef BOOTH_ACCUM_EN
    acc_en = 1'b0;
`endif
    #1;
    check("reset_product", product, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    launch(16'hFFFD, 16'h0007, 1'b1, 1'b0, "signed");
    wait_done("signed", 0);
    check("signed_value", product, 32'hFFFFFFEB);
    launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "unsigned");
    wait_done("unsigned", 0);
    check("unsigned_value", product, 32'hFFFE0001);
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "minus1sq");
    wait_done("minus1sq", 0);
    launch(16'h8000, 16'h8000, 1'b1, 1'b0, "minsq");
    wait_done("minsq", 0);
    check("minsq_value", product, 32'h40000000);
    launch(16'h7FFF, 16'h8000, 1'b1, 1'b0, "maxmin");
    wait_done("maxmin", 0);
    check("maxmin_value", product, 32'hC0008000);

    // Asynchronous reset between edges clears outputs at once.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_product", product, 0);
    check("async_rst_busy", busy, 0);
    exp_prod = '0;
    @(negedge clk);
    reset = 1'b0;

    // start pulsed at E+3 with different operands must be ignored.
    launch(16'd1234, 16'd77, 1'b0, 1'b0, "ign_start");
    @(negedge clk);
    @(negedge clk);
    in_A = 16'd999; in_B = 16'd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_busy", busy, 1);
    wait_done("ign_start", 3);

    // Reset in the middle of CALC: no done, product cleared.
    launch(16'd321, 16'd123, 1'b0, 1'b0, "mid_rst");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_product", product, 0);
    check("mid_rst_busy", busy, 0);
    exp_prod = '0;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("mid_rst_no_done", seen_done, 0);
    check("mid_rst_product_held", product, 0);
    launch(16'd5, 16'd6, 1'b0, 1'b0, "after_rst");
    wait_done("after_rst", 0);
    check("after_rst_value", product, 30);

    // Accumulate sequence; without the feature each result simply overwrites.
    launch(16'd3, 16'd4, 1'b0, 1'b0, "acc0");
    wait_done("acc0", 0);
    launch(16'd5, 16'd6, 1'b0, 1'b1, "acc1");
    wait_done("acc1", 0);
    check("acc1_value", product, ACCUM ? 32'd42 : 32'd30);
    launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "acc2");
    wait_done("acc2", 0);
    check("acc2_value", product, ACCUM ? 32'hFFFE002B : 32'hFFFE0001);

    for (int i = 0; i < 24; i++) begin
      launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), "rand");
      wait_done("rand", 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
